// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master arbiter sequencing fixed-latency accesses on a shared memory port
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req1,
    input  logic        req2,
    input  logic [21:0] addr1,
    input  logic [21:0] addr2,
    input  logic [31:0] wr1,
    input  logic [31:0] wr2,
    input  logic        rw1,
    input  logic        rw2,
    output logic        ack1,
    output logic        ack2,
    output logic [31:0] rdata,
    input  logic [31:0] mem_rdata,
    output logic        sel,
    output logic [21:0] addr,
    output logic [31:0] wr,
    output logic        cs,
    output logic        rw,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t     state, state_nxt;
    logic       prio;
    logic [3:0] cnt;
    logic       grant, grant_sel, done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: grant leaves IDLE, expired wait count leaves ACCESS, ACK lasts one cycle
    always_comb begin
        state_nxt = (state == IDLE)   ? (grant ? ACCESS : IDLE) :
                    (state == ACCESS) ? (done ? ACK : ACCESS) : IDLE;
    end

    // Decode: arbitration decision (prio breaks ties), end-of-wait and busy flag
    always_comb begin
        grant     = (state == IDLE) && (req1 || req2);
        grant_sel = (req1 && req2) ? prio : req2;
        done      = (state == ACCESS) && (cnt == 4'd0);
        busy      = state != IDLE;
    end

    // Memory port, counter, priority pointer and ack registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio  <= 1'b0;
            cnt   <= 4'd0;
            sel   <= 1'b0;
            cs    <= 1'b0;
            rw    <= 1'b0;
            addr  <= '0;
            wr    <= '0;
            rdata <= '0;
            ack1  <= 1'b0;
            ack2  <= 1'b0;
        end else begin
            ack1 <= done && !sel;
            ack2 <= done && sel;
            if (grant) begin
                sel  <= grant_sel;
                addr <= grant_sel ? addr2 : addr1;
                wr   <= grant_sel ? wr2 : wr1;
                rw   <= grant_sel ? rw2 : rw1;
                cs   <= 1'b1;
                cnt  <= CNT_INIT;
            end else if (done) begin
                cs   <= 1'b0;
                prio <= ~sel;
                if (rw) rdata <= mem_rdata;
            end else if (state == ACCESS) begin
                cnt <= cnt - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, access timing, reset abort and WAIT_CYCLES=1
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req1 = 1'b0, req2 = 1'b0, rw1 = 1'b0, rw2 = 1'b0;
    logic [21:0] addr1 = '0, addr2 = '0;
    logic [31:0] wr1 = '0, wr2 = '0, mem_rdata = '0;
    logic        ack1, ack2, sel, cs, rw, busy;
    logic [31:0] rdata, wr;
    logic [21:0] addr;

    logic        b_req1 = 1'b0;
    logic [31:0] b_mem_rdata = '0;
    logic        b_ack1, b_ack2, b_sel, b_cs, b_rw, b_busy;
    logic [31:0] b_rdata, b_wr;
    logic [21:0] b_addr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req1(req1), .req2(req2), .addr1(addr1), .addr2(addr2),
        .wr1(wr1), .wr2(wr2), .rw1(rw1), .rw2(rw2),
        .ack1(ack1), .ack2(ack2), .rdata(rdata), .mem_rdata(mem_rdata),
        .sel(sel), .addr(addr), .wr(wr), .cs(cs), .rw(rw), .busy(busy)
    );

    mem_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req1(b_req1), .req2(1'b0), .addr1(22'h00ABC), .addr2(22'h0),
        .wr1(32'h0), .wr2(32'h0), .rw1(1'b1), .rw2(1'b0),
        .ack1(b_ack1), .ack2(b_ack2), .rdata(b_rdata), .mem_rdata(b_mem_rdata),
        .sel(b_sel), .addr(b_addr), .wr(b_wr), .cs(b_cs), .rw(b_rw), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        step();
        step();
        check("rst_sel", 32'(sel), 0);
        check("rst_cs", 32'(cs), 0);
        check("rst_rw", 32'(rw), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_wr", wr, 0);
        check("rst_rdata", rdata, 0);
        check("rst_ack1", 32'(ack1), 0);
        check("rst_ack2", 32'(ack2), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        step();

        // single read on master 1
        addr1 = 22'h00123; rw1 = 1'b1; mem_rdata = 32'hDEADBEEF; req1 = 1'b1;
        step();
        check("rd_cs1", 32'(cs), 1);
        check("rd_sel", 32'(sel), 0);
        check("rd_addr", 32'(addr), 32'h00123);
        check("rd_rw", 32'(rw), 1);
        check("rd_busy", 32'(busy), 1);
        step();
        check("rd_cs2", 32'(cs), 1);
        check("rd_ack_early", 32'(ack1), 0);
        step();
        check("rd_ack1", 32'(ack1), 1);
        check("rd_ack2", 32'(ack2), 0);
        check("rd_cs_off", 32'(cs), 0);
        check("rd_rdata", rdata, 32'hDEADBEEF);
        check("rd_busy_ack", 32'(busy), 1);
        req1 = 1'b0;
        step();
        check("rd_ack1_done", 32'(ack1), 0);
        check("rd_idle", 32'(busy), 0);

        // single write on master 2
        addr2 = 22'h3FFFFF; wr2 = 32'hA5A5A5A5; rw2 = 1'b0; mem_rdata = 32'h11111111; req2 = 1'b1;
        step();
        check("wr_sel", 32'(sel), 1);
        check("wr_rw", 32'(rw), 0);
        check("wr_wr", wr, 32'hA5A5A5A5);
        check("wr_addr", 32'(addr), 32'h3FFFFF);
        check("wr_cs1", 32'(cs), 1);
        step();
        check("wr_cs2", 32'(cs), 1);
        step();
        check("wr_ack2", 32'(ack2), 1);
        check("wr_ack1", 32'(ack1), 0);
        check("wr_rdata", rdata, 32'hDEADBEEF);
        req2 = 1'b0;
        step();
        check("wr_ack2_done", 32'(ack2), 0);

        // tie after reset: alternating grants 1,2,1,2
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        addr1 = 22'h00001; addr2 = 22'h00002; rw1 = 1'b1; rw2 = 1'b1;
        req1 = 1'b1; req2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            mem_rdata = 32'h10000000 + 32'(i);
            check($sformatf("tie%0d_sel", i), 32'(sel), 32'(i % 2));
            check($sformatf("tie%0d_addr", i), 32'(addr), 32'(i % 2 + 1));
            check($sformatf("tie%0d_cs", i), 32'(cs), 1);
            step();
            check($sformatf("tie%0d_cs2", i), 32'(cs), 1);
            step();
            check($sformatf("tie%0d_ack1", i), 32'(ack1), 32'(i % 2 == 0));
            check($sformatf("tie%0d_ack2", i), 32'(ack2), 32'(i % 2 == 1));
            check($sformatf("tie%0d_rdata", i), rdata, 32'h10000000 + 32'(i));
            if (i == 3) begin req1 = 1'b0; req2 = 1'b0; end
            step();
            check($sformatf("tie%0d_gap", i), 32'(cs), 0);
            check($sformatf("tie%0d_noack", i), 32'(ack1 | ack2), 0);
        end

        // request withdrawn during ACCESS
        rw1 = 1'b0; wr1 = 32'h0BADF00D; req1 = 1'b1;
        step();
        check("wd_cs1", 32'(cs), 1);
        req1 = 1'b0;
        step();
        check("wd_cs2", 32'(cs), 1);
        step();
        check("wd_ack1", 32'(ack1), 1);
        check("wd_rdata", rdata, 32'h10000003);
        step();
        check("wd_ack1_once", 32'(ack1), 0);
        step();
        check("wd_no_regrant", 32'(cs), 0);

        // reset during the second cs cycle
        rw1 = 1'b1; req1 = 1'b1;
        step();
        check("ra_cs1", 32'(cs), 1);
        step();
        check("ra_cs2", 32'(cs), 1);
        rst_n = 1'b0;
        #1;
        check("ra_cs_async", 32'(cs), 0);
        check("ra_busy_async", 32'(busy), 0);
        check("ra_ack_async", 32'(ack1), 0);
        req1 = 1'b0;
        step();
        step();
        check("ra_no_ack", 32'(ack1), 0);
        rst_n = 1'b1;
        req2 = 1'b1;
        step();
        check("ra_m2_sel", 32'(sel), 1);
        check("ra_m2_cs", 32'(cs), 1);
        step();
        step();
        check("ra_m2_ack", 32'(ack2), 1);
        req2 = 1'b0;
        step();

        // WAIT_CYCLES = 1, back-to-back reads on master 1
        b_mem_rdata = 32'hCAFE0001; b_req1 = 1'b1;
        step();
        check("w1_cs_a", 32'(b_cs), 1);
        check("w1_sel", 32'(b_sel), 0);
        check("w1_addr", 32'(b_addr), 32'h00ABC);
        check("w1_rw", 32'(b_rw), 1);
        step();
        check("w1_ack_a", 32'(b_ack1), 1);
        check("w1_cs_off_a", 32'(b_cs), 0);
        check("w1_rdata_a", b_rdata, 32'hCAFE0001);
        b_mem_rdata = 32'hCAFE0002;
        step();
        check("w1_gap", 32'(b_cs), 0);
        check("w1_gap_busy", 32'(b_busy), 0);
        step();
        check("w1_cs_b", 32'(b_cs), 1);
        step();
        check("w1_ack_b", 32'(b_ack1), 1);
        check("w1_ack2", 32'(b_ack2), 0);
        check("w1_wr", b_wr, 0);
        check("w1_rdata_b", b_rdata, 32'hCAFE0002);
        b_req1 = 1'b0;
        step();
        check("w1_end", 32'(b_cs), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
